clock_hms_setter: RTL and testbench
===================================

Name: clock_hms_setter

Overview:
Parametrised successor of the 12-hour clock/setter pair. One block owns the running hh:mm:ss time base, a button-driven set FSM with a shadow register, and an external load path. It presents time in 12-hour or 24-hour format, selectable at run time. It sits between the debounced/pulsed button logic and the 7-segment display driver, and is the single time source for alarm and stopwatch blocks.

Parameters:
TICK_DIV, 50000000, clk cycles per second; must be ≥ 2.
PS_W, 26, prescaler counter width; must satisfy 2^PS_W ≥ TICK_DIV.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset; sampled on rising clk edge, 0 resets
mode_24  in  1  1 = 24-hour display, 0 = 12-hour display with is_pm
pulsed_set  in  1  one-cycle pulse: enter set / advance field / commit
pulsed_up  in  1  one-cycle pulse: increment selected field
pulsed_down  in  1  one-cycle pulse: decrement selected field
load  in  1  one-cycle external load strobe, 24-hour values
load_hours  in  5  0..23
load_minutes  in  6  0..59
load_seconds  in  6  0..59
state  out  2  0=RUN, 1=SET_H, 2=SET_M, 3=SET_S
disp_hours  out  5  display hours: 0..23 in 24h mode, 1..12 in 12h mode
disp_minutes  out  6  display minutes
disp_seconds  out  6  display seconds
is_pm  out  1  1 when the displayed 24h hour ≥ 12, valid in both modes
hours24  out  5  running time hours, always 24h, never the shadow value
sec_tick  out  1  one-cycle pulse when running time advances
load_err  out  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset (reset=0 at a clk edge): time 00:00:00, shadow 00:00:00, prescaler 0, state RUN, sec_tick=0, load_err=0. Displayed outputs then read 12:00:00 with is_pm=0 in 12h mode, 00:00:00 in 24h mode. Reset overrides all other inputs.
- Prescaler counts 0..TICK_DIV-1. On the cycle it equals TICK_DIV-1, the registered time increments and sec_tick=1 on the next cycle, so sec_tick is a registered pulse with one-cycle latency.
- Increment rules: sec 59→0 carries to minutes; min 59→0 carries to hours; hours 23→0. 23:59:59 rolls to 00:00:00.
- Running time keeps advancing in every state, including the SET states.
- FSM transitions:
  - RUN + pulsed_set: shadow ← current time, go to SET_H.
  - SET_H + pulsed_set: go to SET_M.
  - SET_M + pulsed_set: go to SET_S.
  - SET_S + pulsed_set: commit. Time ← shadow, prescaler ← 0, go to RUN.
- In SET_x, pulsed_up/pulsed_down change only the selected shadow field, modulo its range: hours 0..23, min/sec 0..59. There is no carry between fields. 0 decremented gives 23 or 59.
- pulsed_up and pulsed_down asserted in the same cycle: no change. Up/down in RUN: ignored.
- While in a SET state, the disp_* and is_pm outputs show the shadow. In RUN they show the running time. hours24 always shows the running time.
- 12h conversion is combinational from the registered 24h value:
  - h=0 → 12, is_pm=0.
  - h=1..11 → h, is_pm=0.
  - h=12 → 12, is_pm=1.
  - h=13..23 → h-12, is_pm=1.
- Load handling (load=1):
  - Accepted only if all three fields are in range. Then time ← load values, prescaler ← 0, state ← RUN; any pending set is aborted and the shadow discarded.
  - Out of range: time and state unchanged, load_err=1 for the next cycle.
- Priority within one cycle: reset > load > commit > tick > set/up/down. A commit or accepted load in the same cycle as a prescaler wrap suppresses that tick and its sec_tick. pulsed_set arriving in the same cycle as an accepted load is ignored.
- All outputs except the 12h conversion path are registered.

Decomposition:
- Package clock_pkg holds:
  - state encoding constants RUN / SET_H / SET_M / SET_S;
  - field limits MAX_H=23 and MAX_MS=59;
  - field widths 5/6.
- One natural sub-module: hour_fmt12, a combinational 24h→12h + is_pm converter, reused by alarm display.
- The wrap-add/sub for shadow fields may be a function in clock_pkg.

Test Plan:
- TICK_DIV=4. Release reset, then run 4*61 cycles. Required: 00:01:01 in 24h; sec_tick every 4th cycle; 12h shows 12:01:01 with is_pm=0.
- Load 23:59:58 in 24h mode, then wait 8 cycles. Required: reads 00:00:00; is_pm goes 1→0; no load_err.
- Set sequence: set, 2×down (hours 00→22), set, 1×up (min +1), set, set. Required: time 22:(m+1):s', prescaler 0, state RUN. During SET_H, disp_hours=10 with is_pm=1 in 12h mode.
- Load 24:00:00. Required: load_err pulses one cycle; time unchanged. Then load 12:30:00 while in SET_M. Required: state RUN, 12h display shows 12:30:00 with is_pm=1.
- up+down in the same cycle in SET_S: shadow unchanged. Prescaler wrap coincident with commit: no sec_tick, time equals shadow.
- Drive reset=0 for one cycle mid-SET_M with a pulsed_set present. Required: next cycle state RUN, 00:00:00, shadow cleared.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared time-of-day types, field limits and the shadow-field wrap helper
// for the clock, alarm and stopwatch blocks.
package clock_pkg;

    localparam int unsigned H_W  = 5;
    localparam int unsigned MS_W = 6;

    localparam logic [H_W-1:0]  MAX_H  = 5'd23;
    localparam logic [MS_W-1:0] MAX_MS = 6'd59;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_e;

    // Modulo step of a single field; up and down together cancel out.
    function automatic logic [MS_W-1:0] step_field(input logic [MS_W-1:0] val,
                                                   input logic [MS_W-1:0] max,
                                                   input logic            up,
                                                   input logic            down);
        logic [MS_W-1:0] res;
        res = val;
        if (up && !down) begin
            res = (val == max) ? '0 : val + 1'b1;
        end else if (down && !up) begin
            res = (val == '0) ? max : val - 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/hour_fmt12.sv
// Combinational 24-hour to 12-hour converter with PM flag; shared with the
// alarm display path.
module hour_fmt12
    import clock_pkg::*;
(
    input  logic [H_W-1:0] hours24,
    output logic [H_W-1:0] hours12,
    output logic           is_pm
);

    always_comb begin
        is_pm = (hours24 >= 5'd12);
        if (hours24 == '0) begin
            hours12 = 5'd12;
        end else if (hours24 > 5'd12) begin
            hours12 = hours24 - 5'd12;
        end else begin
            hours12 = hours24;
        end
    end

endmodule

// File: rtl/clock_hms_setter.sv
// Running hh:mm:ss time base with button-driven set FSM, shadow register,
// external load path and run-time selectable 12h/24h display.
module clock_hms_setter
    import clock_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned PS_W     = 26
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mode_24,
    input  logic            pulsed_set,
    input  logic            pulsed_up,
    input  logic            pulsed_down,
    input  logic            load,
    input  logic [H_W-1:0]  load_hours,
    input  logic [MS_W-1:0] load_minutes,
    input  logic [MS_W-1:0] load_seconds,
    output logic [1:0]      state,
    output logic [H_W-1:0]  disp_hours,
    output logic [MS_W-1:0] disp_minutes,
    output logic [MS_W-1:0] disp_seconds,
    output logic            is_pm,
    output logic [H_W-1:0]  hours24,
    output logic            sec_tick,
    output logic            load_err
);

    state_e          state_q, state_d;
    logic [H_W-1:0]  hh_q, hh_d, sh_h_q, sh_h_d;
    logic [MS_W-1:0] mm_q, mm_d, ss_q, ss_d;
    logic [MS_W-1:0] sh_m_q, sh_m_d, sh_s_q, sh_s_d;
    logic [PS_W-1:0] ps_q, ps_d;
    logic            tick_q, tick_d, err_q, err_d;

    logic wrap, load_ok, commit;

    assign wrap    = (ps_q == PS_W'(TICK_DIV - 1));
    assign load_ok = load && (load_hours <= MAX_H) && (load_minutes <= MAX_MS)
                     && (load_seconds <= MAX_MS);
    assign commit  = (state_q == SET_S) && pulsed_set;

    always_comb begin
        state_d = state_q;
        hh_d    = hh_q;
        mm_d    = mm_q;
        ss_d    = ss_q;
        sh_h_d  = sh_h_q;
        sh_m_d  = sh_m_q;
        sh_s_d  = sh_s_q;
        ps_d    = wrap ? '0 : ps_q + 1'b1;
        tick_d  = 1'b0;
        err_d   = 1'b0;

        if (load_ok) begin
            hh_d    = load_hours;
            mm_d    = load_minutes;
            ss_d    = load_seconds;
            ps_d    = '0;
            state_d = RUN;
        end else begin
            err_d = load;
            if (commit) begin
                hh_d    = sh_h_q;
                mm_d    = sh_m_q;
                ss_d    = sh_s_q;
                ps_d    = '0;
                state_d = RUN;
            end else begin
                if (wrap) begin
                    tick_d = 1'b1;
                    if (ss_q == MAX_MS) begin
                        ss_d = '0;
                        if (mm_q == MAX_MS) begin
                            mm_d = '0;
                            hh_d = (hh_q == MAX_H) ? '0 : hh_q + 1'b1;
                        end else begin
                            mm_d = mm_q + 1'b1;
                        end
                    end else begin
                        ss_d = ss_q + 1'b1;
                    end
                end

                // Shadow captures the pre-tick time on entry to SET_H.
                unique case (state_q)
                    RUN: begin
                        if (pulsed_set) begin
                            sh_h_d  = hh_q;
                            sh_m_d  = mm_q;
                            sh_s_d  = ss_q;
                            state_d = SET_H;
                        end
                    end
                    SET_H: begin
                        sh_h_d = H_W'(step_field({1'b0, sh_h_q}, MS_W'(MAX_H),
                                                 pulsed_up, pulsed_down));
                        if (pulsed_set) state_d = SET_M;
                    end
                    SET_M: begin
                        sh_m_d = step_field(sh_m_q, MAX_MS, pulsed_up, pulsed_down);
                        if (pulsed_set) state_d = SET_S;
                    end
                    SET_S: begin
                        sh_s_d = step_field(sh_s_q, MAX_MS, pulsed_up, pulsed_down);
                    end
                    default: state_d = RUN;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RUN;
            hh_q    <= '0;
            mm_q    <= '0;
            ss_q    <= '0;
            sh_h_q  <= '0;
            sh_m_q  <= '0;
            sh_s_q  <= '0;
            ps_q    <= '0;
            tick_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hh_q    <= hh_d;
            mm_q    <= mm_d;
            ss_q    <= ss_d;
            sh_h_q  <= sh_h_d;
            sh_m_q  <= sh_m_d;
            sh_s_q  <= sh_s_d;
            ps_q    <= ps_d;
            tick_q  <= tick_d;
            err_q   <= err_d;
        end
    end

    logic [H_W-1:0]  sel_h, h12;
    logic [MS_W-1:0] sel_m, sel_s;
    logic            sel_pm;

    assign sel_h = (state_q == RUN) ? hh_q : sh_h_q;
    assign sel_m = (state_q == RUN) ? mm_q : sh_m_q;
    assign sel_s = (state_q == RUN) ? ss_q : sh_s_q;

    hour_fmt12 u_fmt12 (
        .hours24 (sel_h),
        .hours12 (h12),
        .is_pm   (sel_pm)
    );

    assign state        = state_q;
    assign disp_hours   = mode_24 ? sel_h : h12;
    assign disp_minutes = sel_m;
    assign disp_seconds = sel_s;
    assign is_pm        = sel_pm;
    assign hours24      = hh_q;
    assign sec_tick     = tick_q;
    assign load_err     = err_q;

endmodule

// File: tb/tb_clock_hms_setter.sv
// Randomised scoreboard bench for clock_hms_setter against a seconds-of-day
// reference model.
module tb_clock_hms_setter;

    localparam int unsigned TD  = 4;
    localparam int          DAY = 86400;

    logic       clk = 1'b0;
    logic       reset = 1'b0, mode_24 = 1'b1;
    logic       pulsed_set = 1'b0, pulsed_up = 1'b0, pulsed_down = 1'b0, load = 1'b0;
    logic [4:0] load_hours = '0;
    logic [5:0] load_minutes = '0, load_seconds = '0;
    logic [1:0] state;
    logic [4:0] disp_hours, hours24;
    logic [5:0] disp_minutes, disp_seconds;
    logic       is_pm, sec_tick, load_err;

    always #5 clk = ~clk;

    clock_hms_setter #(
        .TICK_DIV (TD),
        .PS_W     (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mode_24      (mode_24),
        .pulsed_set   (pulsed_set),
        .pulsed_up    (pulsed_up),
        .pulsed_down  (pulsed_down),
        .load         (load),
        .load_hours   (load_hours),
        .load_minutes (load_minutes),
        .load_seconds (load_seconds),
        .state        (state),
        .disp_hours   (disp_hours),
        .disp_minutes (disp_minutes),
        .disp_seconds (disp_seconds),
        .is_pm        (is_pm),
        .hours24      (hours24),
        .sec_tick     (sec_tick),
        .load_err     (load_err)
    );

    typedef struct {
        int st, dh, dm, ds, pm, h24, tick, err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0, errors = 0;

    // Reference model: time as seconds of day, shadow as three plain fields.
    int m_t, m_ps, m_st, m_tick, m_err;
    int m_sh[3];

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("state",        int'(state),        mon_e.st);
            chk("disp_hours",   int'(disp_hours),   mon_e.dh);
            chk("disp_minutes", int'(disp_minutes), mon_e.dm);
            chk("disp_seconds", int'(disp_seconds), mon_e.ds);
            chk("is_pm",        int'(is_pm),        mon_e.pm);
            chk("hours24",      int'(hours24),      mon_e.h24);
            chk("sec_tick",     int'(sec_tick),     mon_e.tick);
            chk("load_err",     int'(load_err),     mon_e.err);
        end
    end

    task automatic model_step(input bit rst, input bit s, input bit u, input bit d,
                              input bit ld, input int lh, input int lm, input int ls);
        int t_old, lim;
        if (!rst) begin
            m_t = 0; m_ps = 0; m_st = 0; m_tick = 0; m_err = 0;
            m_sh[0] = 0; m_sh[1] = 0; m_sh[2] = 0;
            return;
        end
        m_tick = 0;
        m_err  = 0;
        t_old  = m_t;
        if (ld && lh < 24 && lm < 60 && ls < 60) begin
            m_t = lh * 3600 + lm * 60 + ls; m_ps = 0; m_st = 0;
        end else begin
            if (ld) m_err = 1;
            if (m_st == 3 && s) begin
                m_t = m_sh[0] * 3600 + m_sh[1] * 60 + m_sh[2]; m_ps = 0; m_st = 0;
            end else begin
                if (m_ps == TD - 1) begin
                    m_ps = 0; m_t = (m_t + 1) % DAY; m_tick = 1;
                end else begin
                    m_ps++;
                end
                if (m_st == 0) begin
                    if (s) begin
                        m_sh[0] = t_old / 3600; m_sh[1] = (t_old / 60) % 60;
                        m_sh[2] = t_old % 60;   m_st = 1;
                    end
                end else begin
                    lim = (m_st == 1) ? 24 : 60;
                    if (u && !d) m_sh[m_st-1] = (m_sh[m_st-1] + 1) % lim;
                    if (d && !u) m_sh[m_st-1] = (m_sh[m_st-1] + lim - 1) % lim;
                    if (s) m_st++;
                end
            end
        end
    endtask

    task automatic cyc(input bit rst, input bit m24, input bit s, input bit u, input bit d,
                       input bit ld, input int lh, input int lm, input int ls);
        exp_t e;
        int   h;
        @(negedge clk);
        reset = rst; mode_24 = m24; pulsed_set = s; pulsed_up = u; pulsed_down = d;
        load = ld; load_hours = 5'(lh); load_minutes = 6'(lm); load_seconds = 6'(ls);
        model_step(rst, s, u, d, ld, lh, lm, ls);
        h      = (m_st == 0) ? m_t / 3600 : m_sh[0];
        e.st   = m_st;
        e.dh   = m24 ? h : ((h % 12 == 0) ? 12 : h % 12);
        e.dm   = (m_st == 0) ? (m_t / 60) % 60 : m_sh[1];
        e.ds   = (m_st == 0) ? m_t % 60 : m_sh[2];
        e.pm   = (h >= 12) ? 1 : 0;
        e.h24  = m_t / 3600;
        e.tick = m_tick;
        e.err  = m_err;
        @(posedge clk);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input bit m24);
        for (int i = 0; i < n; i++) cyc(1, m24, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic press(input bit m24, input bit s, input bit u, input bit d);
        cyc(1, m24, s, u, d, 0, 0, 0, 0);
    endtask

    initial begin
        int a;
        bit m;
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 1, 5, 5, 5);
        idle(4 * 61, 1);
        idle(2, 0);

        cyc(1, 1, 0, 0, 0, 1, 23, 59, 58);
        idle(8, 0);

        press(0, 1, 0, 0);
        press(0, 0, 0, 1);
        press(0, 0, 0, 1);
        idle(2, 0);
        press(0, 1, 0, 0);
        press(0, 0, 1, 0);
        press(0, 1, 0, 0);
        press(0, 1, 0, 0);
        idle(3, 1);

        cyc(1, 1, 0, 0, 0, 1, 24, 0, 0);
        idle(2, 1);
        press(0, 1, 0, 0);
        press(0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 12, 30, 0);
        idle(2, 0);

        press(1, 1, 0, 0);
        press(1, 1, 0, 0);
        press(1, 1, 0, 0);
        press(1, 0, 1, 1);
        for (int i = 0; i < 8 && m_ps != TD - 1; i++) idle(1, 1);
        press(1, 1, 0, 0);
        idle(2, 1);

        press(1, 1, 0, 0);
        press(1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
        idle(3, 1);

        for (int i = 0; i < 3000; i++) begin
            a = int'($urandom_range(0, 15));
            m = 1'($urandom_range(0, 1));
            case (a)
                0:       cyc(($urandom_range(0, 19) != 0), m, 0, 0, 0, 0, 0, 0, 0);
                1, 2:    press(m, 1, 0, 0);
                3:       press(m, 0, 1, 0);
                4:       press(m, 0, 0, 1);
                5:       press(m, 0, 1, 1);
                6:       cyc(1, m, 0, 0, 0, 1, int'($urandom_range(0, 31)),
                             int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
                default: idle(1, m);
            endcase
        end

        repeat (2) @(posedge clk);
        #3;
        chk("scoreboard_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
